// File: rtl/acc_requant_pkg.sv
// Shared constants and FSM encoding for the accumulate-and-requantize block.
package acc_requant_pkg;

   localparam int TAPS_DEF  = 9;
   localparam int ACC_W_DEF = 36;
   localparam int INT8_MAX  = 127;
   localparam int INT8_MIN  = -128;

   typedef enum logic [1:0] {
      ACC_IDLE = 2'd0,
      ACC_RUN  = 2'd1
   } acc_state_e;

endpackage

// File: rtl/acc_requant_if.sv
// Product stream in, requantized int8 result out.
interface acc_requant_if;

   logic               clear;
   logic               prod_valid;
   logic signed [31:0] prod_in;
   logic signed [31:0] bias;
   logic        [4:0]  shift;
   logic               relu_en;
   logic               busy;
   logic               out_valid;
   logic signed [7:0]  out_data;
   logic               sat;

   modport master (
      output clear, prod_valid, prod_in, bias, shift, relu_en,
      input  busy, out_valid, out_data, sat
   );

   modport slave (
      input  clear, prod_valid, prod_in, bias, shift, relu_en,
      output busy, out_valid, out_data, sat
   );

endinterface

// File: rtl/acc_requant_requant_sat8.sv
// Combinational round-half-up right shift, int8 saturation, then optional ReLU.
module requant_sat8
   import acc_requant_pkg::*;
#(
   parameter int W = ACC_W_DEF + 1
) (
   input  logic signed [W-1:0] sum,
   input  logic        [4:0]   shift,
   input  logic                relu_en,
   output logic signed [7:0]   q,
   output logic                sat
);

   localparam logic signed [W:0] MAX_V = (W+1)'(INT8_MAX);
   localparam logic signed [W:0] MIN_V = (W+1)'(INT8_MIN);

   logic signed [W:0] rnd;
   logic signed [W:0] half;
   logic signed [W:0] r;

   // One guard bit above the input keeps the rounding add from overflowing.
   always_comb begin
      rnd  = (W+1)'(sum);
      half = '0;
      if (shift != 5'd0) begin
         half = (W+1)'(1) << (shift - 5'd1);
      end
      r   = (rnd + half) >>> shift;
      q   = r[7:0];
      sat = 1'b0;
      if (r > MAX_V) begin
         q   = 8'(INT8_MAX);
         sat = 1'b1;
      end else if (r < MIN_V) begin
         q   = 8'(INT8_MIN);
         sat = 1'b1;
      end
      if (relu_en && q[7]) begin
         q   = '0;
         sat = 1'b0;
      end
   end

endmodule

// File: rtl/acc_requant.sv
// Sums TAPS signed products per window, adds bias, and emits one requantized int8 per window.
module acc_requant
   import acc_requant_pkg::*;
#(
   parameter int TAPS  = TAPS_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input logic         clk,
   input logic         rst,
   acc_requant_if.slave bus
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

   acc_state_e               state;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W:0]    sum_q;
   logic [4:0]               shift_q;
   logic                     relu_q;
   logic                     out_valid_q;

   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W:0]    sum_next;
   logic                     legal;
   logic signed [7:0]        q;
   logic                     q_sat;

   // A window's first product ignores whatever acc holds from the previous window.
   always_comb begin
      prod_ext = ACC_W'(bus.prod_in);
      acc_base = (cnt == '0) ? '0 : acc;
      sum_next = (ACC_W+1)'(acc_base) + (ACC_W+1)'(prod_ext) + (ACC_W+1)'(bus.bias);
      legal    = ((state == ACC_IDLE) && (cnt == '0)) ||
                 ((state == ACC_RUN) && (cnt != '0) && (cnt <= LAST));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ACC_IDLE;
         cnt         <= '0;
         acc         <= '0;
         sum_q       <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (bus.clear || !legal) begin
            state <= ACC_IDLE;
            cnt   <= '0;
         end else if (bus.prod_valid) begin
            if (cnt == LAST) begin
               sum_q       <= sum_next;
               shift_q     <= bus.shift;
               relu_q      <= bus.relu_en;
               out_valid_q <= 1'b1;
               cnt         <= '0;
               state       <= ACC_IDLE;
            end else begin
               acc   <= acc_base + prod_ext;
               cnt   <= cnt + CNT_W'(1);
               state <= ACC_RUN;
            end
         end
      end
   end

   // The latched window sum stays put, so out_data holds until the next pulse.
   requant_sat8 #(.W(ACC_W + 1)) u_requant (
      .sum     (sum_q),
      .shift   (shift_q),
      .relu_en (relu_q),
      .q       (q),
      .sat     (q_sat)
   );

   assign bus.busy      = (state == ACC_RUN);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = q;
   assign bus.sat       = q_sat;

endmodule

// File: doc/acc_requant.md
ACC_REQUANT -- requirements
Module: acc_requant

Interface
REQ-001 Parameter TAPS, default 9, the number of products summed per output window (3x3 kernel).
REQ-002 Parameter ACC_W, default 36, the accumulator width in bits; it SHALL be at least 32+ceil(log2(TAPS)).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous abort of the current partial window.
REQ-006 prod_valid  input  1  prod_in carries a valid product this cycle.
REQ-007 prod_in  input  32  signed two's-complement product from the 8x9 multiplier stage, already sign-extended.
REQ-008 bias  input  32  signed bias, sampled at the edge that captures the TAPS-th product.
REQ-009 shift  input  5  requantization right-shift amount, 0..31, sampled with bias.
REQ-010 relu_en  input  1  clamp negative results to 0, sampled with bias.
REQ-011 busy  output  1  high while a partial window (1..TAPS-1 products) is held.
REQ-012 out_valid  output  1  single-cycle pulse marking a new out_data.
REQ-013 out_data  output  8  signed int8 requantized result, held until the next out_valid.
REQ-014 sat  output  1  saturation occurred for the current out_data, updated with out_valid.

Function
REQ-015 Each cycle with prod_valid=1 and clear=0 SHALL consume exactly one product; cycles with prod_valid=0 SHALL leave all window state unchanged, and gaps of any length are legal.
REQ-016 A product count cnt (0..TAPS-1) and a signed ACC_W accumulator SHALL be kept; the first product of a window loads acc = sext(prod_in), and each later product adds acc = acc + sext(prod_in).
REQ-017 When the TAPS-th product is consumed, the edge SHALL latch sum = acc + sext(prod_in) + sext(bias) together with shift and relu_en into the output stage, reset cnt to 0, and drop busy.
REQ-018 Latency: out_valid SHALL be 1 exactly one cycle after the edge that consumed the TAPS-th product, for one cycle only.
REQ-019 Requantization: if shift=0 then r=sum, else r=(sum + 2^(shift-1)) >>> shift (arithmetic shift, round-half-up).
REQ-020 Saturation: if r>127 then out_data=127 and sat=1; if r<-128 then out_data=-128 and sat=1; otherwise out_data=r[7:0] and sat=0.
REQ-021 ReLU: if relu_en=1 and the result is negative, out_data=0 and sat=0 (ReLU is applied after saturation).
REQ-022 Back-to-back windows: a product arriving in the cycle out_valid is high SHALL start the next window with no bubble, sustaining one output per TAPS valid cycles.
REQ-023 clear=1 SHALL discard the partial window (cnt=0, busy=0), ignore prod_in that cycle, and SHALL NOT cancel an out_valid already due in that cycle.
REQ-024 The accumulator SHALL NOT wrap for TAPS products of full-range 32-bit inputs plus bias; ACC_W+1 bits SHALL be used for the bias add.
REQ-025 FSM states: ACC_IDLE (cnt=0), ACC_RUN (0<cnt<TAPS), plus a one-cycle output register stage; an illegal cnt SHALL recover to ACC_IDLE.

Reset
REQ-026 While rst=0: cnt=0, acc=0, busy=0, out_valid=0, out_data=0, sat=0, immediately and independent of clk.
REQ-027 Reset mid-window SHALL lose the partial sum, with no out_valid after release; the first valid product after release starts a new window.

Structure
REQ-028 A shared package SHALL hold TAPS default, ACC_W default, int8 bounds (127/-128) and the FSM state encoding.
REQ-029 Requantization (round, shift, saturate, ReLU) SHALL be a combinational sub-module requant_sat8 (ACC_W+1-bit signed in, 5-bit shift, relu_en; 8-bit out plus sat).

Verification
REQ-030 9 products of 1, bias=0, shift=0, relu_en=0 -> out_valid one cycle after the 9th, out_data=9, sat=0.
REQ-031 9 products of 100, bias=128, shift=8 -> sum=1028, r=4, out_data=4; with bias=-1028-129 and relu_en=1 -> out_data=0.
REQ-032 9 products of 0x7FFFFFFF, shift=0 -> out_data=127, sat=1; 9 products of 0x80000000 -> out_data=-128, sat=1 (no wrap).
REQ-033 Two windows of 18 back-to-back products (values 1..18), shift=0 -> out_data=45 then 126, out_valid pulses 9 cycles apart.
REQ-034 5 products with random prod_valid gaps, then clear, then 9 products of 2 -> a single out_valid, out_data=18.
REQ-035 rst asserted asynchronously after 4 products, released, then 9 products of -3 -> all outputs 0 during reset, then out_data=-27.
